multiplicador_booth: RTL and testbench
======================================

MULTIPLICADOR_BOOTH -- requirements
Module: multiplicador_booth

Interface
REQ-001 Parameter N, default 4, SHALL set the operand width in bits, N >= 2.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL be the request; only a 0->1 transition, sampled on clk, SHALL begin an operation.
REQ-005 signed_mode  input  1  SHALL select two's-complement operands (1) or unsigned operands (0), sampled with start.
REQ-006 B_in  input  N  SHALL be the multiplicand.
REQ-007 Q_in  input  N  SHALL be the multiplier.
REQ-008 busy  output  1  SHALL be high while an operation is in progress.
REQ-009 done  output  1  SHALL be high while a valid result is held.
REQ-010 P_out  output  2N  SHALL be the registered product.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-012 The block SHALL register start each cycle (start_q); "accept" means state is IDLE or DONE, start=1 and start_q=0.
REQ-013 On accept at edge k, the block SHALL latch B_in, Q_in and signed_mode, and sign-extend (signed) or zero-extend (unsigned) both operands to N+1 bits.
REQ-014 On the same edge it SHALL clear the accumulator and the Booth bit Q(-1), load the iteration counter with N+1, and enter CALC.
REQ-015 On accept, done SHALL fall at edge k and P_out SHALL hold its previous value until the new result is written.
REQ-016 Each CALC cycle SHALL perform one radix-2 Booth step:
- {Q0,Q(-1)}=01 -> add M to the accumulator.
- 10 -> subtract M.
- 00/11 -> no change.
- Then arithmetic-shift {A,Q,Q(-1)} right by 1 and decrement the counter.
REQ-017 The accumulator and M SHALL be N+2 bits wide so that no step overflows for either mode.
REQ-018 After the step that brings the counter to 0 (edge k+N+1), the FSM SHALL enter DONE and write P_out with the low 2N bits of {A,Q}.
REQ-019 Latency from accept to done=1 SHALL be exactly N+1 cycles, independent of operand values, including zero operands.
REQ-020 busy SHALL equal (state==CALC).
REQ-021 done SHALL equal (state==DONE) and SHALL stay high until the next accept or reset.
REQ-022 start transitions during CALC SHALL be ignored, and operand changes during CALC SHALL NOT affect the result.
REQ-023 start held high continuously SHALL produce exactly one operation; a new operation requires start to return to 0 first.
REQ-024 An accept in DONE SHALL restart immediately, with no intermediate IDLE cycle.
REQ-025 The result SHALL be exact for the full range: unsigned 0..(2^N-1)^2, and signed, including -2^(N-1) * -2^(N-1).

Reset
REQ-026 rst=0 SHALL immediately set state=IDLE, busy=0, done=0, P_out=0, start_q=0, and clear the counter, accumulator and operand registers, regardless of clock.
REQ-027 Reset asserted during CALC SHALL abort the operation with no partial result visible on P_out.
REQ-028 The first accept after reset release SHALL require start to be sampled 0 for at least one cycle after release.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10) and the Booth opcode constants.
REQ-030 A sub-module somador_subtrator, parametrised for N+2 bits, SHALL implement add/subtract of M into the accumulator; all other logic SHALL stay in multiplicador_booth.

Verification (N=4)
REQ-031 Unsigned basic: signed_mode=0, B_in=0111, Q_in=0101, start 0->1 -> done after exactly 5 cycles, P_out=8'h23, busy high for those 5 cycles.
REQ-032 Unsigned extremes: B_in=1111, Q_in=1111 -> P_out=8'hE1; B_in=1001, Q_in=0111 -> P_out=8'h3F.
REQ-033 Signed: signed_mode=1, B_in=1001 (-7), Q_in=0111 -> P_out=8'hCF; B_in=1000, Q_in=1000 -> P_out=8'h40; B_in=0000, Q_in=1011 -> P_out=8'h00 after 5 cycles.
REQ-034 Handshake: start held high for 30 cycles -> exactly one operation; a second 0->1 in DONE restarts, with done low at the next edge.
REQ-035 Start pulses and operand changes during CALC -> no effect; result still 8'h23.
REQ-036 Reset: rst=0 two cycles into CALC -> busy=0, done=0, P_out=0 asynchronously; after release, a new accept yields the correct product.

Source files
------------

// File: rtl/multiplicador_booth_pkg.sv
// Shared constants for the radix-2 Booth multiplier: FSM encoding and
// the Booth recoding of the {Q0, Q(-1)} bit pair.
package multiplicador_booth_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [1:0] OP_NOP0 = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_NOP1 = 2'b11;

endpackage

// File: rtl/multiplicador_booth_somador_subtrator.sv
// Accumulator adder/subtractor: o_y = i_a + i_b, or i_a - i_b when i_sub.
module somador_subtrator #(
    parameter int W = 6
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_y
);

    assign o_y = i_sub ? (i_a - i_b) : (i_a + i_b);

endmodule

// File: rtl/multiplicador_booth.sv
// Sequential radix-2 Booth multiplier, signed or unsigned N-bit operands,
// one Booth step per clock, result after exactly N+1 steps.
//
//   state   | meaning
//   IDLE    | after reset, waiting for a start rising edge
//   CALC    | one Booth step per cycle, counter counts down to 0
//   DONE    | P_out valid, waiting for the next start rising edge
module multiplicador_booth
    import multiplicador_booth_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   B_in,
    input  logic [N-1:0]   Q_in,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] P_out
);

    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N + 1);

    logic [1:0]     r_state;
    logic           r_start_q;
    logic           r_armed;
    logic [CW-1:0]  r_cnt;
    logic [N+1:0]   r_a;
    logic [N+1:0]   r_m;
    logic [N:0]     r_q;
    logic           r_qm1;
    logic [2*N-1:0] r_pout;

    logic           w_accept;
    logic [N:0]     w_b_ext;
    logic [N:0]     w_q_ext;
    logic [1:0]     w_op;
    logic [N+1:0]   w_sum;
    logic [N+1:0]   w_a_step;
    logic [N+1:0]   w_a_sh;
    logic [N:0]     w_q_sh;
    logic [2*N-1:0] w_p_next;

    // r_armed keeps a start held high across reset release from being accepted
    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                      start && !r_start_q && r_armed;

    assign w_b_ext = signed_mode ? {B_in[N-1], B_in} : {1'b0, B_in};
    assign w_q_ext = signed_mode ? {Q_in[N-1], Q_in} : {1'b0, Q_in};

    assign w_op = {r_q[0], r_qm1};

    somador_subtrator #(.W(N + 2)) u_somador (
        .i_a   (r_a),
        .i_b   (r_m),
        .i_sub (w_op == OP_SUB),
        .o_y   (w_sum)
    );

    assign w_a_step = ((w_op == OP_ADD) || (w_op == OP_SUB)) ? w_sum : r_a;
    assign w_a_sh   = {w_a_step[N+1], w_a_step[N+1:1]};
    assign w_q_sh   = {w_a_step[0], r_q[N:1]};
    // Low 2N bits of the shifted {A,Q}
    assign w_p_next = {w_a_step[N-1:0], r_q[N:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_armed   <= 1'b0;
            r_cnt     <= '0;
            r_a       <= '0;
            r_m       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_pout    <= '0;
        end else begin
            r_start_q <= start;
            if (!start) r_armed <= 1'b1;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_m     <= {w_b_ext[N], w_b_ext};
                        r_q     <= w_q_ext;
                        r_a     <= '0;
                        r_qm1   <= 1'b0;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_a   <= w_a_sh;
                    r_q   <= w_q_sh;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_pout  <= w_p_next;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy  = (r_state == ST_CALC);
    assign done  = (r_state == ST_DONE);
    assign P_out = r_pout;

endmodule

// File: tb/tb_multiplicador_booth.sv
// Directed + random bench for multiplicador_booth (N=4) with a result scoreboard.
module tb_multiplicador_booth;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           signed_mode = 1'b0;
    logic [N-1:0]   B_in = '0;
    logic [N-1:0]   Q_in = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] P_out;

    int checks = 0;
    int failures = 0;
    logic [2*N-1:0] sb[$];
    logic [2*N-1:0] last_p = '0;

    multiplicador_booth #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .B_in        (B_in),
        .Q_in        (Q_in),
        .busy        (busy),
        .done        (done),
        .P_out       (P_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] model(input bit m, input logic [N-1:0] b, input logic [N-1:0] q);
        int bi;
        int qi;
        if (m) begin
            bi = int'($signed(b));
            qi = int'($signed(q));
        end else begin
            bi = int'({1'b0, b});
            qi = int'({1'b0, q});
        end
        return (2*N)'(bi * qi);
    endfunction

    // Drops start for one cycle, then raises it with new operands; leaves start high.
    task automatic do_accept(input bit m, input logic [N-1:0] b, input logic [N-1:0] q,
                             input logic [2*N-1:0] exp);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        signed_mode = m;
        B_in = b;
        Q_in = q;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        chk("accept_busy", busy, 1);
        chk("accept_done_low", done, 0);
        chk("pout_hold", P_out, last_p);
    endtask

    task automatic wait_done(input bit disturb);
        int cyc;
        int busy_err;
        logic [2*N-1:0] exp;
        cyc = 0;
        busy_err = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            if (!busy) busy_err++;
            if (P_out !== last_p) busy_err++;
            if (disturb) begin
                start = ~start;
                signed_mode = ~signed_mode;
                B_in = N'($urandom_range(0, 15));
                Q_in = N'($urandom_range(0, 15));
            end
        end
        chk("latency", cyc, N + 1);
        chk("busy_during_calc", busy_err, 0);
        chk("busy_low_in_done", busy, 0);
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            chk("product", P_out, exp);
            last_p = exp;
        end else begin
            chk("scoreboard_empty", 1, 0);
        end
    endtask

    initial begin
        logic [N-1:0] rb;
        logic [N-1:0] rq;
        bit           rm;
        int           bad;

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pout", P_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        do_accept(0, 4'b0111, 4'b0101, 8'h23); wait_done(0);
        do_accept(0, 4'b1111, 4'b1111, 8'hE1); wait_done(0);
        do_accept(0, 4'b1001, 4'b0111, 8'h3F); wait_done(0);
        do_accept(1, 4'b1001, 4'b0111, 8'hCF); wait_done(0);
        do_accept(1, 4'b1000, 4'b1000, 8'h40); wait_done(0);
        do_accept(1, 4'b0000, 4'b1011, 8'h00); wait_done(0);
        do_accept(0, 4'b0000, 4'b0000, 8'h00); wait_done(0);

        for (int i = 0; i < 6; i++) begin
            rb = N'($urandom_range(0, 15));
            rq = N'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            do_accept(rm, rb, rq, model(rm, rb, rq));
            wait_done(0);
        end

        // start held high: exactly one operation
        do_accept(0, 4'b0111, 4'b0101, 8'h23);
        wait_done(0);
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1;
            if (!done || busy || P_out !== last_p) bad++;
        end
        chk("held_start_one_op", bad, 0);

        // restart straight from DONE
        do_accept(1, 4'b1000, 4'b0111, 8'hC8); wait_done(0);

        // start pulses and operand changes during CALC are ignored
        do_accept(0, 4'b0111, 4'b0101, 8'h23); wait_done(1);

        // asynchronous reset two cycles into CALC
        do_accept(1, 4'b1001, 4'b0111, 8'hCF);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pout", P_out, 0);
        void'(sb.pop_front());
        last_p = '0;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_accept(0, 4'b1001, 4'b0111, 8'h3F); wait_done(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
